ttt_turn_controller: RTL

- Tic-tac-toe game sequencer. Owns the 3x3 board register and alternates turns between player 1 and player 2.
- Drives one-hot enablers into the existing illegal-move checker and commits only legal moves.
- Detects win or draw after each move.
- Sits between the player input front-end (buttons/decoder) and the board/display logic.

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/ttt_win_detect.sv | 29 ++
 rtl/ttt_turn_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
// Cell codes, FSM state encoding and the win-line index table.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_TURN,
        S_P2_TURN,
        S_CHECK,
        S_EVAL,
        S_GAME_OVER
    } state_t;

    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // rows, columns, then both diagonals
    localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational win/draw detector over a committed board.
// Reports whether the given player holds any line and whether the board is full.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  board_t     i_board,
    input  logic [1:0] i_player,
    output logic       o_line_win,
    output logic       o_board_full
);

    always_comb begin
        o_line_win   = 1'b0;
        o_board_full = 1'b1;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (i_board[WIN_LINES[l][0]] == i_player &&
                i_board[WIN_LINES[l][1]] == i_player &&
                i_board[WIN_LINES[l][2]] == i_player) begin
                o_line_win = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (i_board[c] == CELL_EMPTY) begin
                o_board_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the board, alternates players, commits legal moves.
// Optional idle auto-move enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       illegal,
    output logic [8:0] player1_enabler,
    output logic [8:0] player2_enabler,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] current_player,
    output logic       move_ack,
    output logic       move_reject,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t     r_state;
    board_t     r_board;
    logic [8:0] r_en1;
    logic [8:0] r_en2;
    logic [1:0] r_mover;
    logic [3:0] r_pos;
    logic [1:0] r_winner;
    logic       r_ack;
    logic       r_rej;

    state_t     w_state_nx;
    board_t     w_board_nx;
    logic [8:0] w_en1_nx;
    logic [8:0] w_en2_nx;
    logic [1:0] w_mover_nx;
    logic [3:0] w_pos_nx;
    logic [1:0] w_winner_nx;
    logic       w_ack_nx;
    logic       w_rej_nx;

    logic       w_in_turn;
    logic       w_xfer;
    logic       w_pos_ok;
    logic       w_timeout;
    logic [3:0] w_auto_pos;
    logic       w_take;
    logic [3:0] w_take_pos;
    logic [8:0] w_onehot;
    logic [1:0] w_turn_code;
    logic       w_line_win;
    logic       w_board_full;

    assign w_in_turn   = (r_state == S_P1_TURN) || (r_state == S_P2_TURN);
    assign w_xfer      = move_valid && w_in_turn;
    assign w_pos_ok    = (move_pos <= 4'd8);
    assign w_take      = (w_xfer && w_pos_ok) || w_timeout;
    assign w_take_pos  = w_xfer ? move_pos : w_auto_pos;
    assign w_onehot    = 9'd1 << w_take_pos;
    assign w_turn_code = (r_state == S_P1_TURN) ? CELL_P1 : CELL_P2;

`ifdef TTT_TURN_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // a turn state is never entered with a full board, so an empty cell exists
    always_comb begin
        w_auto_pos = 4'd0;
        for (int c = NUM_CELLS - 1; c >= 0; c--) begin
            if (r_board[c] == CELL_EMPTY) begin
                w_auto_pos = 4'(c);
            end
        end
    end

    assign w_timeout = w_in_turn && !w_xfer &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_in_turn && w_state_nx == r_state) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_auto_pos   = 4'd0;
    assign w_unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
`endif

    ttt_win_detect u_win (
        .i_board      (r_board),
        .i_player     (r_mover),
        .o_line_win   (w_line_win),
        .o_board_full (w_board_full)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_board_nx  = r_board;
        w_en1_nx    = '0;
        w_en2_nx    = '0;
        w_mover_nx  = r_mover;
        w_pos_nx    = r_pos;
        w_winner_nx = r_winner;
        w_ack_nx    = 1'b0;
        w_rej_nx    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_board_nx = '0;
                    w_state_nx = S_P1_TURN;
                end
            end
            S_P1_TURN, S_P2_TURN: begin
                if (w_take) begin
                    w_mover_nx = w_turn_code;
                    w_pos_nx   = w_take_pos;
                    if (r_state == S_P1_TURN) begin
                        w_en1_nx = w_onehot;
                    end else begin
                        w_en2_nx = w_onehot;
                    end
                    w_state_nx = S_CHECK;
                end else if (w_xfer) begin
                    w_rej_nx = 1'b1;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    w_rej_nx   = 1'b1;
                    w_state_nx = (r_mover == CELL_P1) ? S_P1_TURN : S_P2_TURN;
                end else begin
                    w_board_nx[r_pos] = r_mover;
                    w_ack_nx          = 1'b1;
                    w_state_nx        = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_line_win) begin
                    w_winner_nx = r_mover;
                    w_state_nx  = S_GAME_OVER;
                end else if (w_board_full) begin
                    w_winner_nx = CELL_EMPTY;
                    w_state_nx  = S_GAME_OVER;
                end else begin
                    w_state_nx = (r_mover == CELL_P1) ? S_P2_TURN : S_P1_TURN;
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    w_board_nx  = '0;
                    w_winner_nx = CELL_EMPTY;
                    w_state_nx  = S_P1_TURN;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_board  <= '0;
            r_en1    <= '0;
            r_en2    <= '0;
            r_mover  <= CELL_EMPTY;
            r_pos    <= '0;
            r_winner <= CELL_EMPTY;
            r_ack    <= 1'b0;
            r_rej    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_board  <= w_board_nx;
            r_en1    <= w_en1_nx;
            r_en2    <= w_en2_nx;
            r_mover  <= w_mover_nx;
            r_pos    <= w_pos_nx;
            r_winner <= w_winner_nx;
            r_ack    <= w_ack_nx;
            r_rej    <= w_rej_nx;
        end
    end

    assign move_ready      = w_in_turn;
    assign player1_enabler = r_en1;
    assign player2_enabler = r_en2;
    assign move_ack        = r_ack;
    assign move_reject     = r_rej;
    assign game_over       = (r_state == S_GAME_OVER);
    assign winner          = r_winner;
    assign current_player  = (r_state == S_P1_TURN) ? CELL_P1 :
                             (r_state == S_P2_TURN) ? CELL_P2 : CELL_EMPTY;

    assign pos1 = r_board[0];
    assign pos2 = r_board[1];
    assign pos3 = r_board[2];
    assign pos4 = r_board[3];
    assign pos5 = r_board[4];
    assign pos6 = r_board[5];
    assign pos7 = r_board[6];
    assign pos8 = r_board[7];
    assign pos9 = r_board[8];

endmodule
